systolic_matmul_engine: RTL and testbench

- Parametrised, non-square ROWS x COLS output-stationary systolic matrix-multiply engine for the TPU datapath.
- Computes C[ROWS][COLS] = A[ROWS][K] * B[K][COLS] in signed Q-format fixed point, with K chosen per job at run time.
- Adds internal input skewing, valid/ready operand streaming with bubbles, automatic flush, and row-by-row result drain with backpressure.
- Sits between the operand buffers and the result writeback path.

---
 rtl/systolic_matmul_engine_pkg.sv | 48 ++++
 rtl/systolic_matmul_engine_mac_pe.sv | 65 ++++++
 rtl/systolic_matmul_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_systolic_matmul_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_matmul_engine_pkg.sv
// Shared types and fixed-point helpers for the systolic matrix-multiply engine.
// The helpers work on a 64-bit carrier so any N up to 64 can use them;
// callers pass their own width/shift and narrow the result.
// sat_add and clamp_n are only referenced when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int FX_W = 64;

  // Full-width signed product, arithmetic shift right by q (floor rounding).
  function automatic logic signed [2*FX_W-1:0] fx_mul(input logic signed [FX_W-1:0] x,
                                                       input logic signed [FX_W-1:0] y,
                                                       input int q);
    logic signed [2*FX_W-1:0] xe;
    logic signed [2*FX_W-1:0] ye;
    xe = {{FX_W{x[FX_W-1]}}, x};
    ye = {{FX_W{y[FX_W-1]}}, y};
    return (xe * ye) >>> q;
  endfunction

  // Clamp a wide signed value into the signed n-bit range.
  function automatic logic signed [FX_W-1:0] clamp_n(input logic signed [2*FX_W-1:0] v,
                                                      input int n);
    logic signed [2*FX_W-1:0] hi;
    logic signed [2*FX_W-1:0] lo;
    hi = (128'sd1 <<< (n - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (n - 1));
    if (v > hi)      return $signed(hi[FX_W-1:0]);
    else if (v < lo) return $signed(lo[FX_W-1:0]);
    else             return $signed(v[FX_W-1:0]);
  endfunction

  // Saturating add into the signed n-bit range.
  function automatic logic signed [FX_W-1:0] sat_add(input logic signed [FX_W-1:0] a,
                                                      input logic signed [FX_W-1:0] b,
                                                      input int n);
    logic signed [2*FX_W-1:0] s;
    s = {{FX_W{a[FX_W-1]}}, a} + {{FX_W{b[FX_W-1]}}, b};
    return clamp_n(s, n);
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_mac_pe.sv
// One output-stationary processing element: multiply-accumulate of the
// incoming x/y pair, forwarding x right and y down through one register each.
// With SYSTOLIC_SAT_EN the product is clamped and the sum saturates; otherwise
// the accumulator wraps.
module mac_pe
  import systolic_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] y_in,
  output logic signed [N-1:0] x_out,
  output logic signed [N-1:0] y_out,
  output logic signed [N-1:0] acc
);

  logic signed [N-1:0] x_q, x_d;
  logic signed [N-1:0] y_q, y_d;
  logic signed [N-1:0] acc_q, acc_d;
  logic signed [N-1:0] upd;

  // Next-state: clear on job start, otherwise advance only when the array is enabled.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
`ifdef SYSTOLIC_SAT_EN
    upd = N'(sat_add(FX_W'(acc_q), clamp_n(fx_mul(FX_W'(x_in), FX_W'(y_in), Q), N), N));
`else
    upd = acc_q + N'(fx_mul(FX_W'(x_in), FX_W'(y_in), Q));
`endif
    if (clr) begin
      x_d   = '0;
      y_d   = '0;
      acc_d = '0;
    end else if (en) begin
      x_d   = x_in;
      y_d   = y_in;
      acc_d = upd;
    end
  end

  // PE state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary ROWS x COLS systolic matmul engine: C = A * B with run-time K.
// Operand beats stream in over a valid/ready handshake (bubbles freeze the
// array), the skew chains are flushed with zeros, then rows drain one per
// handshake. Optional macro SYSTOLIC_SAT_EN selects saturating arithmetic.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int Q    = 10,
  parameter int N    = 32,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int KMAX = 256,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ROWS*N-1:0]       a_data,
  input  logic [COLS*N-1:0]       b_data,
  output logic                    busy,
  output logic                    done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [COLS*N-1:0]       res_row,
  output logic [$clog2(ROWS)-1:0] res_idx
);

  localparam int IW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   bcnt_q, bcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            a_ready_q, a_ready_d;
  logic            res_valid_q, res_valid_d;
  logic            done_q, done_d;
  logic            beat, en, clr;
  logic            unused_edge;

  logic signed [N-1:0] xw    [ROWS][COLS+1];
  logic signed [N-1:0] yw    [ROWS+1][COLS];
  logic signed [N-1:0] acc_w [ROWS][COLS];

  assign beat = a_valid & a_ready_q;
  assign en   = beat | (state_q == FLUSH);

  // FSM next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    bcnt_d      = bcnt_q;
    fcnt_d      = fcnt_q;
    idx_d       = idx_q;
    a_ready_d   = a_ready_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr    = 1'b1;
          k_d    = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
          bcnt_d = '0;
          fcnt_d = '0;
          idx_d  = '0;
          if (k_len == '0) begin
            state_d     = DRAIN;
            res_valid_d = 1'b1;
          end else begin
            state_d   = FEED;
            a_ready_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (beat) begin
          if (bcnt_q == k_q - KW'(1)) begin
            state_d   = FLUSH;
            a_ready_d = 1'b0;
            bcnt_d    = '0;
          end else begin
            bcnt_d = bcnt_q + KW'(1);
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          state_d     = DRAIN;
          res_valid_d = 1'b1;
          fcnt_d      = '0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (idx_q == IW'(ROWS - 1)) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            done_d      = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      bcnt_q      <= '0;
      fcnt_q      <= '0;
      idx_q       <= '0;
      a_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      bcnt_q      <= bcnt_d;
      fcnt_q      <= fcnt_d;
      idx_q       <= idx_d;
      a_ready_q   <= a_ready_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    logic signed [N-1:0] a_in;
    assign a_in = (state_q == FLUSH) ? '0 : $signed(a_data[i*N +: N]);
    if (i == 0) begin : g_dir
      assign xw[i][0] = a_in;
    end else begin : g_chain
      logic signed [N-1:0] sk_q [i];
      logic signed [N-1:0] sk_d [i];
      // Row skew: shift one stage per enabled cycle, cleared at job start.
      always_comb begin
        sk_d = sk_q;
        if (clr) begin
          for (int s = 0; s < i; s++) sk_d[s] = '0;
        end else if (en) begin
          sk_d[0] = a_in;
          for (int s = 1; s < i; s++) sk_d[s] = sk_q[s-1];
        end
      end
      // Row skew registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign xw[i][0] = sk_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    logic signed [N-1:0] b_in;
    assign b_in = (state_q == FLUSH) ? '0 : $signed(b_data[j*N +: N]);
    if (j == 0) begin : g_dir
      assign yw[0][j] = b_in;
    end else begin : g_chain
      logic signed [N-1:0] sk_q [j];
      logic signed [N-1:0] sk_d [j];
      // Column skew: shift one stage per enabled cycle, cleared at job start.
      always_comb begin
        sk_d = sk_q;
        if (clr) begin
          for (int s = 0; s < j; s++) sk_d[s] = '0;
        end else if (en) begin
          sk_d[0] = b_in;
          for (int s = 1; s < j; s++) sk_d[s] = sk_q[s-1];
        end
      end
      // Column skew registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < j; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign yw[0][j] = sk_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      mac_pe #(.N(N), .Q(Q)) u_pe (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .x_in (xw[i][j]),
        .y_in (yw[i][j]),
        .x_out(xw[i][j+1]),
        .y_out(yw[i+1][j]),
        .acc  (acc_w[i][j])
      );
    end
  end

  // Operands leaving the far edges of the grid have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edge = unused_edge ^ (^xw[i][COLS]);
    for (int j = 0; j < COLS; j++) unused_edge = unused_edge ^ (^yw[ROWS][j]);
  end

  // Present the accumulators of the selected row.
  always_comb begin
    res_row = '0;
    for (int j = 0; j < COLS; j++) res_row[j*N +: N] = acc_w[idx_q][j];
  end

  assign a_ready   = a_ready_q;
  assign res_valid = res_valid_q;
  assign done      = done_q;
  assign res_idx   = idx_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed bench for systolic_matmul_engine: three 4x4 instances share control
// (Q=0/N=32, Q=10/N=32, Q=0/N=16) so jobs run in lockstep; each scenario checks
// the instance whose expected values were hand-computed.
module tb_systolic_matmul_engine;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic a_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [R*32-1:0] a32 = '0;
  logic [C*32-1:0] b32 = '0;
  logic [R*16-1:0] a16 = '0;
  logic [C*16-1:0] b16 = '0;

  logic a_ready0, busy0, done0, res_valid0;
  logic a_ready1, busy1, done1, res_valid1;
  logic a_ready2, busy2, done2, res_valid2;
  logic [C*32-1:0] row0, row1;
  logic [C*16-1:0] row2;
  logic [1:0] idx0, idx1, idx2;

  int total = 0;
  int bad = 0;
  int av[R];
  int bv[C];
  longint exp_c[R][C];

  always #5 clk = ~clk;

  systolic_matmul_engine #(.Q(0), .N(32), .ROWS(R), .COLS(C)) d0 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_valid(a_valid),
    .a_ready(a_ready0), .a_data(a32), .b_data(b32), .busy(busy0), .done(done0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_row(row0), .res_idx(idx0));

  systolic_matmul_engine #(.Q(10), .N(32), .ROWS(R), .COLS(C)) d10 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_valid(a_valid),
    .a_ready(a_ready1), .a_data(a32), .b_data(b32), .busy(busy1), .done(done1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_row(row1), .res_idx(idx1));

  systolic_matmul_engine #(.Q(0), .N(16), .ROWS(R), .COLS(C)) d16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_valid(a_valid),
    .a_ready(a_ready2), .a_data(a16), .b_data(b16), .busy(busy2), .done(done2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_row(row2), .res_idx(idx2));

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint elem(input int sel, input int j);
    case (sel)
      0:       return longint'($signed(row0[j*32 +: 32]));
      1:       return longint'($signed(row1[j*32 +: 32]));
      default: return longint'($signed(row2[j*16 +: 16]));
    endcase
  endfunction

  function automatic longint o_valid(input int sel);
    case (sel) 0: return longint'(res_valid0); 1: return longint'(res_valid1); default: return longint'(res_valid2); endcase
  endfunction
  function automatic longint o_ready(input int sel);
    case (sel) 0: return longint'(a_ready0); 1: return longint'(a_ready1); default: return longint'(a_ready2); endcase
  endfunction
  function automatic longint o_done(input int sel);
    case (sel) 0: return longint'(done0); 1: return longint'(done1); default: return longint'(done2); endcase
  endfunction
  function automatic longint o_busy(input int sel);
    case (sel) 0: return longint'(busy0); 1: return longint'(busy1); default: return longint'(busy2); endcase
  endfunction
  function automatic longint o_idx(input int sel);
    case (sel) 0: return longint'(idx0); 1: return longint'(idx1); default: return longint'(idx2); endcase
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < R; i++) begin
      a32[i*32 +: 32] = 32'(av[i]);
      a16[i*16 +: 16] = 16'(av[i]);
    end
    for (int j = 0; j < C; j++) begin
      b32[j*32 +: 32] = 32'(bv[j]);
      b16[j*16 +: 16] = 16'(bv[j]);
    end
  endtask

  task automatic set_exp_all(input longint v);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) exp_c[i][j] = v;
  endtask

  // Leaves the bench at the negedge right after start was sampled.
  task automatic do_start(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int sel, input int k, input int gap);
    pack_ops();
    for (int b = 0; b < k; b++) begin
      a_valid = 1'b1;
      check_val($sformatf("a_ready_beat%0d", b), o_ready(sel), 1);
      @(negedge clk);
      a_valid = 1'b0;
      if (b != k - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_res(input int sel, input int exp_lat);
    int n = 0;
    check_val("a_ready_drop", o_ready(sel), 0);
    while (o_valid(sel) == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("res_latency", n, exp_lat);
  endtask

  // Called at a negedge with res_valid expected high.
  task automatic drain_rows(input int sel, input int hold, input bit poke_start);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 1) begin
        start = 1'b1;
        k_len = KW'(2);
      end
      @(negedge clk);
      start = 1'b0;
      check_val("hold_valid", o_valid(sel), 1);
      check_val("hold_idx", o_idx(sel), 0);
      check_val("hold_row", elem(sel, C - 1), exp_c[0][C-1]);
    end
    for (int i = 0; i < R; i++) begin
      check_val($sformatf("row%0d_valid", i), o_valid(sel), 1);
      check_val($sformatf("row%0d_idx", i), o_idx(sel), i);
      check_val($sformatf("row%0d_done", i), o_done(sel), 0);
      check_val($sformatf("row%0d_aready", i), o_ready(sel), 0);
      for (int j = 0; j < C; j++)
        check_val($sformatf("c[%0d][%0d]", i, j), elem(sel, j), exp_c[i][j]);
      res_ready = 1'b1;
      @(negedge clk);
    end
    res_ready = 1'b0;
    check_val("done_pulse", o_done(sel), 1);
    check_val("valid_after", o_valid(sel), 0);
    @(negedge clk);
    check_val("done_single", o_done(sel), 0);
    check_val("busy_idle", o_busy(sel), 0);
  endtask

  initial begin
    // Reset state.
    #1;
    check_val("rst_busy", busy0, 0);
    check_val("rst_aready", a_ready0, 0);
    check_val("rst_valid", res_valid0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_idx", idx0, 0);
    check_val("rst_row", longint'(row0[63:0]), 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic timing: k=1, a=[1,2,3,4], b=1 -> row i = i+1.
    av = '{1, 2, 3, 4};
    bv = '{1, 1, 1, 1};
    do_start(1);
    check_val("busy_feed", busy0, 1);
    feed(0, 1, 0);
    wait_res(0, 7);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) exp_c[i][j] = i + 1;
    drain_rows(0, 0, 1'b0);

    // Fixed point with two-cycle bubbles, then backpressure in drain.
    av = '{1536, 1536, 1536, 1536};
    bv = '{2048, 2048, 2048, 2048};
    do_start(3);
    feed(1, 3, 2);
    wait_res(1, 7);
    set_exp_all(9216);
    drain_rows(1, 5, 1'b0);

    // Same job without bubbles gives the same result.
    do_start(3);
    feed(1, 3, 0);
    wait_res(1, 7);
    drain_rows(1, 0, 1'b0);

    // Zero K: straight to drain with all-zero rows.
    do_start(0);
    check_val("k0_valid", res_valid0, 1);
    check_val("k0_aready", a_ready0, 0);
    set_exp_all(0);
    drain_rows(0, 0, 1'b0);

    // Reset after two of three beats aborts the job.
    av = '{5, 5, 5, 5};
    bv = '{3, 3, 3, 3};
    do_start(3);
    feed(0, 2, 0);
    rst = 1'b0;
    #1;
    check_val("abort_busy", busy0, 0);
    check_val("abort_aready", a_ready0, 0);
    check_val("abort_valid", res_valid0, 0);
    check_val("abort_done", done0, 0);
    check_val("abort_row", longint'(row0[63:0]), 0);
    @(negedge clk);
    check_val("abort_done_hold", done0, 0);
    rst = 1'b1;

    // Clean job after reset; a start pulse during drain is ignored.
    av = '{1, 2, 3, 4};
    bv = '{2, 2, 2, 2};
    do_start(1);
    feed(0, 1, 0);
    wait_res(0, 7);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) exp_c[i][j] = 2 * (i + 1);
    drain_rows(0, 3, 1'b1);
    @(negedge clk);
    check_val("start_ignored", busy0, 0);

    // Overflow on the 16-bit instance: 200*200 twice.
    av = '{200, 200, 200, 200};
    bv = '{200, 200, 200, 200};
    do_start(2);
    feed(2, 2, 0);
    wait_res(2, 7);
`ifdef SYSTOLIC_SAT_EN
    set_exp_all(32767);
`else
    set_exp_all(14464);
`endif
    drain_rows(2, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
